// File: rtl/patch_eval_pkg.sv
// Shared types for the patch netlist evaluator: gate opcodes, stored gate
// records and FSM states, plus opcode classification helpers.
package patch_eval_pkg;

    localparam int PE_NUM_PI    = 3;
    localparam int PE_MAX_GATES = 16;
    localparam int PE_IDX_W     = $clog2(PE_NUM_PI + PE_MAX_GATES);

    typedef enum logic [3:0] {
        AND  = 4'd0,
        OR   = 4'd1,
        NAND = 4'd2,
        NOR  = 4'd3,
        XOR  = 4'd4,
        XNOR = 4'd5,
        BUF  = 4'd6,
        INV  = 4'd7,
        C0   = 4'd8,
        C1   = 4'd9
    } gate_op_e;

    typedef struct packed {
        gate_op_e              op;
        logic [PE_IDX_W-1:0]   in0;
        logic [PE_IDX_W-1:0]   in1;
    } gate_rec_t;

    typedef enum logic [2:0] {
        LOAD  = 3'd0,
        EVAL  = 3'd1,
        CHECK = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } state_e;

    function automatic logic op_legal(logic [3:0] op);
        return op <= 4'd9;
    endfunction

    // Constants read no operand; BUF/INV read only in0.
    function automatic logic uses_in0(logic [3:0] op);
        return op <= 4'd7;
    endfunction

    function automatic logic uses_in1(logic [3:0] op);
        return op <= 4'd5;
    endfunction

endpackage

// File: rtl/gate_alu.sv
// Combinational evaluation of a single 2-input gate.
module gate_alu
    import patch_eval_pkg::*;
(
    input  logic [3:0] op_i,
    input  logic       a_i,
    input  logic       b_i,
    output logic       y_o
);

    always_comb begin
        y_o = 1'b0;
        case (gate_op_e'(op_i))
            AND:     y_o = a_i & b_i;
            OR:      y_o = a_i | b_i;
            NAND:    y_o = ~(a_i & b_i);
            NOR:     y_o = ~(a_i | b_i);
            XOR:     y_o = a_i ^ b_i;
            XNOR:    y_o = ~(a_i ^ b_i);
            BUF:     y_o = a_i;
            INV:     y_o = ~a_i;
            C0:      y_o = 1'b0;
            C1:      y_o = 1'b1;
            default: y_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/patch_netlist_evaluator.sv
// Loads a topologically ordered gate list and exhaustively simulates it,
// one gate per cycle, comparing the selected output with a golden table.
module patch_netlist_evaluator
    import patch_eval_pkg::*;
#(
    parameter  int NUM_PI    = PE_NUM_PI,
    parameter  int MAX_GATES = PE_MAX_GATES,
    localparam int IDX_W     = $clog2(NUM_PI + MAX_GATES)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rec_valid,
    output logic                     rec_ready,
    input  logic [3:0]               rec_op,
    input  logic [IDX_W-1:0]         rec_in0,
    input  logic [IDX_W-1:0]         rec_in1,
    input  logic                     rec_last,
    input  logic [IDX_W-1:0]         out_sel,
    input  logic [(1<<NUM_PI)-1:0]   golden_tt,
    input  logic                     clear,
    output logic                     busy,
    output logic                     done,
    output logic                     equiv,
    output logic [NUM_PI-1:0]        fail_vec,
    output logic                     err
);

    localparam int NUM_SIG = NUM_PI + MAX_GATES;
    localparam int CNT_W   = $clog2(MAX_GATES + 1);
    localparam int GI_W    = $clog2(MAX_GATES);
    localparam int NVEC    = 1 << NUM_PI;
    localparam int SIG_W   = 1 << IDX_W;
    localparam logic [NUM_PI-1:0] VEC_LAST = '1;

    state_e                  state_q;
    logic [CNT_W-1:0]        gate_cnt_q;
    logic [CNT_W-1:0]        gi_q;
    logic [NUM_PI-1:0]       vec_q;
    logic [NUM_PI-1:0]       fail_vec_q;
    logic                    equiv_q;
    logic [IDX_W-1:0]        out_sel_q;
    logic [NVEC-1:0]         golden_q;
    logic [MAX_GATES-1:0]    gsig_q;
    gate_rec_t               mem_q [MAX_GATES];

    logic [SIG_W-1:0]        sig_all;
    logic [IDX_W:0]          lim;
    gate_rec_t               cur;
    logic                    alu_y;
    logic                    accept;
    logic                    rec_bad;
    logic                    out_bad;

    // Full signal space: PIs come straight from the current vector, padded
    // to a power of two so any index width selects safely.
    always_comb begin
        sig_all = '0;
        sig_all[NUM_SIG-1:0] = {gsig_q, vec_q};
    end

    assign rec_ready = (state_q == LOAD);
    assign accept    = rec_valid && rec_ready;
    assign lim       = (IDX_W+1)'(NUM_PI) + (IDX_W+1)'(gate_cnt_q);
    assign rec_bad   = (gate_cnt_q == CNT_W'(MAX_GATES)) || !op_legal(rec_op) ||
                       (uses_in0(rec_op) && ({1'b0, rec_in0} >= lim)) ||
                       (uses_in1(rec_op) && ({1'b0, rec_in1} >= lim));
    assign out_bad   = ({1'b0, out_sel} >= (lim + (IDX_W+1)'(1)));
    assign cur       = mem_q[gi_q[GI_W-1:0]];

    gate_alu u_alu (
        .op_i (cur.op),
        .a_i  (sig_all[cur.in0]),
        .b_i  (sig_all[cur.in1]),
        .y_o  (alu_y)
    );

    always_ff @(posedge clk) begin
        if (accept && !rec_bad)
            mem_q[gate_cnt_q[GI_W-1:0]] <= '{op: gate_op_e'(rec_op), in0: rec_in0, in1: rec_in1};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= LOAD;
            gate_cnt_q <= '0;
            gi_q       <= '0;
            vec_q      <= '0;
            fail_vec_q <= '0;
            equiv_q    <= 1'b0;
            out_sel_q  <= '0;
            golden_q   <= '0;
            gsig_q     <= '0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (accept) begin
                        if (rec_bad || (rec_last && out_bad)) begin
                            state_q <= ERR;
                        end else begin
                            gate_cnt_q <= gate_cnt_q + 1'b1;
                            if (rec_last) begin
                                out_sel_q <= out_sel;
                                golden_q  <= golden_tt;
                                vec_q     <= '0;
                                gi_q      <= '0;
                                gsig_q    <= '0;
                                state_q   <= EVAL;
                            end
                        end
                    end
                end
                EVAL: begin
                    gsig_q[gi_q[GI_W-1:0]] <= alu_y;
                    if (gi_q == gate_cnt_q - 1'b1)
                        state_q <= CHECK;
                    else
                        gi_q <= gi_q + 1'b1;
                end
                CHECK: begin
                    if (sig_all[out_sel_q] != golden_q[vec_q]) begin
                        fail_vec_q <= vec_q;
                        equiv_q    <= 1'b0;
                        state_q    <= DONE;
                    end else if (vec_q == VEC_LAST) begin
                        equiv_q <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        vec_q   <= vec_q + 1'b1;
                        gi_q    <= '0;
                        state_q <= EVAL;
                    end
                end
                DONE, ERR: begin
                    if (clear) begin
                        gate_cnt_q <= '0;
                        equiv_q    <= 1'b0;
                        fail_vec_q <= '0;
                        state_q    <= LOAD;
                    end
                end
                default: state_q <= LOAD;
            endcase
        end
    end

    assign busy     = (state_q == EVAL) || (state_q == CHECK);
    assign done     = (state_q == DONE);
    assign err      = (state_q == ERR);
    assign equiv    = equiv_q;
    assign fail_vec = fail_vec_q;

endmodule
